// File: rtl/mux_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_8
// Description : Round-robin arbiter that owns the select of a shared 8:1 bit
//               mux (two 4:1 muxes plus a final 2:1 stage) and grants it to
//               one of 8 requesters at a time, for at most MAX_HOLD
//               consecutive cycles per turn. The selected bit is registered
//               on y and qualified by valid.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset
//               req    - [7:0] level-sensitive requests
//               a      - [7:0] data bits into the shared mux
//               sel    - [2:0] registered mux select (granted index)
//               gnt    - [7:0] registered one-hot grant, zero when idle
//               valid  - registered, y carries a granted requester's bit
//               y      - registered mux output a[sel]
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter_8 #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] a,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       valid,
    output logic       y
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD);

    state_t             r_state, w_state_n;
    logic [2:0]         r_sel,   w_sel_n;
    logic [7:0]         r_gnt,   w_gnt_n;
    logic [2:0]         r_ptr,   w_ptr_n;
    logic [HOLD_W-1:0]  r_cnt,   w_cnt_n;
    logic               r_valid;
    logic               r_y;

    // ------------------------------------------------------------------
    // Shared 8:1 mux: two 4:1 muxes on sel[1:0], then a 2:1 on sel[2].
    // ------------------------------------------------------------------
    logic [1:0] w_mux4;
    logic       w_mux;

    generate
        for (genvar j = 0; j < 2; j++) begin : g_mux4
            logic [3:0] w_grp;
            assign w_grp     = a[4*j +: 4];
            assign w_mux4[j] = w_grp[r_sel[1:0]];
        end
    endgenerate

    assign w_mux = r_sel[2] ? w_mux4[1] : w_mux4[0];

    // ------------------------------------------------------------------
    // Winner search. When the current holder releases, the new pointer
    // (sel+1) is used immediately so handoff happens in the same cycle.
    // Requests are rotated so the priority index lands at bit 0, the
    // lowest set bit is found, and the offset is added back mod 8.
    // ------------------------------------------------------------------
    logic [2:0]  w_arb_ptr;
    logic [15:0] w_rot_full;
    logic [7:0]  w_rot;
    logic [2:0]  w_off;
    logic [2:0]  w_win;
    logic        w_any;

    assign w_arb_ptr  = (r_state == ST_GRANT) ? (r_sel + 3'd1) : r_ptr;
    assign w_rot_full = {req, req} >> w_arb_ptr;
    assign w_rot      = w_rot_full[7:0];
    assign w_any      = |req;

    always_comb begin
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
    end

    assign w_win = w_arb_ptr + w_off;

    // ------------------------------------------------------------------
    // Grant FSM next state
    // ------------------------------------------------------------------
    logic w_release;
    assign w_release = !req[r_sel] || (r_cnt == c_max_hold);

    always_comb begin
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_gnt_n   = r_gnt;
        w_ptr_n   = r_ptr;
        w_cnt_n   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_gnt_n = 8'h00;
                if (w_any) begin
                    w_state_n = ST_GRANT;
                    w_sel_n   = w_win;
                    w_gnt_n   = 8'b1 << w_win;
                    w_cnt_n   = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (!w_release) begin
                    w_cnt_n = r_cnt + HOLD_W'(1);
                end else begin
                    w_ptr_n = r_sel + 3'd1;
                    if (w_any) begin
                        w_sel_n = w_win;
                        w_gnt_n = 8'b1 << w_win;
                        w_cnt_n = HOLD_W'(1);
                    end else begin
                        w_state_n = ST_IDLE;
                        w_gnt_n   = 8'h00;
                        w_cnt_n   = '0;
                    end
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_gnt_n   = 8'h00;
            end
        endcase
    end

    // valid reflects the requester currently holding the mux still asking
    // for it; a dropped request therefore yields one invalid cycle.
    logic w_valid_n;
    assign w_valid_n = (r_state == ST_GRANT) && req[r_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_gnt   <= 8'h00;
            r_ptr   <= 3'd0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sel   <= w_sel_n;
            r_gnt   <= w_gnt_n;
            r_ptr   <= w_ptr_n;
            r_cnt   <= w_cnt_n;
            r_valid <= w_valid_n;
            r_y     <= w_valid_n ? w_mux : 1'b0;
        end
    end

    assign sel   = r_sel;
    assign gnt   = r_gnt;
    assign valid = r_valid;
    assign y     = r_y;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter_8
// Description : Self-checking bench for mux_rr_arbiter_8. A behavioural
//               reference model predicts gnt/sel/valid/y for every cycle;
//               predictions are queued when stimulus is driven and popped
//               when the DUT outputs are sampled. Directed constant checks
//               cover the key scenario points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter_8;

    localparam int MAX_HOLD = 4;
    localparam int HOLD_W   = 3;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] a;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       valid;
    logic       y;

    mux_rr_arbiter_8 #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .a     (a),
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       y;
    } exp_t;

    exp_t q_exp[$];

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    bit       m_grant;
    int       m_sel, m_ptr, m_cnt;
    bit       m_valid, m_y;
    bit [7:0] m_gnt;

    function automatic int find_winner(input bit [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit r_rst, input bit [7:0] r_req, input bit [7:0] r_a);
        bit vn, yn;
        int w;
        if (r_rst) begin
            m_grant = 0; m_sel = 0; m_gnt = 0; m_valid = 0; m_y = 0; m_ptr = 0; m_cnt = 0;
            return;
        end
        vn = m_grant && r_req[m_sel];
        yn = vn ? r_a[m_sel] : 1'b0;
        if (!m_grant) begin
            w = find_winner(r_req, m_ptr);
            if (w >= 0) begin
                m_grant = 1; m_sel = w; m_gnt = 8'(1 << w); m_cnt = 1;
            end else begin
                m_gnt = 0;
            end
        end else if (!r_req[m_sel] || m_cnt == MAX_HOLD) begin
            m_ptr = (m_sel + 1) % 8;
            w = find_winner(r_req, m_ptr);
            if (w >= 0) begin
                m_sel = w; m_gnt = 8'(1 << w); m_cnt = 1;
            end else begin
                m_grant = 0; m_gnt = 0; m_cnt = 0;
            end
        end else begin
            m_cnt++;
        end
        m_valid = vn;
        m_y     = yn;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle: apply inputs, predict, advance an edge, compare.
    task automatic step(input bit r_rst, input bit [7:0] r_req, input bit [7:0] r_a, input string tag);
        exp_t e;
        exp_t o;
        rst = r_rst; req = r_req; a = r_a;
        model_edge(r_rst, r_req, r_a);
        e.gnt = m_gnt; e.sel = 3'(m_sel); e.valid = m_valid; e.y = m_y;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        o.gnt = gnt; o.sel = sel; o.valid = valid; o.y = y;
        n_checks++;
        assert (o === e) else begin
            n_fails++;
            $error("FAIL %s: observed gnt=%h sel=%0d valid=%b y=%b expected gnt=%h sel=%0d valid=%b y=%b",
                   tag, o.gnt, o.sel, o.valid, o.y, e.gnt, e.sel, e.valid, e.y);
        end
    endtask

    int vlow;
    int grant_seq[$];

    initial begin
        rst = 1'b1; req = 8'h00; a = 8'h00;

        // 1. reset with all requests active
        step(1, 8'hFF, 8'hFF, "reset0");
        step(1, 8'hFF, 8'hFF, "reset1");
        check8("reset_gnt", gnt, 8'h00);
        check8("reset_outs", {4'h0, sel, valid, y}, 8'h00);

        // 2. single requester holds, grant re-issued without a gap
        step(0, 8'h04, 8'h04, "single_t1");
        check8("single_gnt", gnt, 8'h04);
        check8("single_sel", {5'h0, sel}, 8'd2);
        step(0, 8'h04, 8'h04, "single_t2");
        check8("single_valid_y", {6'h0, valid, y}, 8'h03);
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h04, 8'h04, "single_hold");
            check8("single_no_gap", gnt, 8'h04);
        end

        // 3. all requesting, full rotation with alternating data
        step(1, 8'h00, 8'h00, "rst3");
        grant_seq.delete();
        for (int i = 0; i < 34; i++) begin
            step(0, 8'hFF, 8'hAA, "rotate");
            if (i % 4 == 0) grant_seq.push_back(int'(sel));
        end
        for (int i = 0; i < 9; i++) begin
            check8("rotate_order", 8'(grant_seq[i]), 8'(i % 8));
        end

        // 4. request 0 drops mid-grant, handoff straight to 7
        step(1, 8'h00, 8'h00, "rst4");
        step(0, 8'h81, 8'hFF, "drop_g");
        check8("drop_first", gnt, 8'h01);
        step(0, 8'h81, 8'hFF, "drop_c1");
        step(0, 8'h81, 8'hFF, "drop_c2");
        step(0, 8'h80, 8'hFF, "drop_rel");
        check8("drop_gnt", gnt, 8'h80);
        check8("drop_sel", {5'h0, sel}, 8'd7);
        check8("drop_valid", {7'h0, valid}, 8'h00);
        vlow = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h80, 8'hFF, "drop_after");
            if (!valid) vlow++;
        end
        check8("drop_valid_once", 8'(vlow), 8'd0);

        // 5. pointer wrap: after grant to 6, order 7,0,1
        step(1, 8'h00, 8'h00, "rst5");
        step(0, 8'h40, 8'h55, "wrap_g6");
        check8("wrap_g6", gnt, 8'h40);
        step(0, 8'h83, 8'h55, "wrap_to7");
        check8("wrap_7", gnt, 8'h80);
        for (int i = 0; i < 4; i++) step(0, 8'h83, 8'h55, "wrap_a");
        check8("wrap_0", gnt, 8'h01);
        for (int i = 0; i < 4; i++) step(0, 8'h83, 8'h55, "wrap_b");
        check8("wrap_1", gnt, 8'h02);

        // 6. reset mid-grant restarts arbitration at requester 0
        step(1, 8'h00, 8'h00, "rst6");
        step(0, 8'h20, 8'hFF, "mid_g5");
        step(0, 8'h20, 8'hFF, "mid_h");
        check8("mid_gnt5", gnt, 8'h20);
        step(1, 8'h21, 8'hFF, "mid_rst");
        check8("mid_rst_out", {gnt[7:2], valid, y}, 8'h00);
        check8("mid_rst_gnt", gnt, 8'h00);
        step(0, 8'h21, 8'hFF, "mid_g0");
        check8("mid_next0", gnt, 8'h01);
        for (int i = 0; i < 4; i++) step(0, 8'h21, 8'hFF, "mid_hold0");
        check8("mid_next5", gnt, 8'h20);

        // MAX_HOLD-agnostic idle return
        step(0, 8'h00, 8'hFF, "idle_rel");
        step(0, 8'h00, 8'hFF, "idle");
        check8("idle_gnt", gnt, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Watchdog: the directed sequence is short; never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
